// File: rtl/seg_scan_capture.sv
// -----------------------------------------------------------------------------
// seg_scan_capture
//   Receiving end of a multiplexed seven-segment scan bus. Each cycle the
//   registered sample {en_seg, data_seg, dt} is classified as idle, a single
//   digit, or a collision. A digit is accepted once STABLE_CYC consecutive
//   identical samples have been seen. Accepted digits are rebuilt as parallel
//   registers with valid flags, a frame-wrap pulse, a sticky collision flag
//   and an optional stale indication.
//
// Parameters
//   NUM_DIG      digit positions on the bus (2..4)
//   STABLE_CYC   identical samples required to accept a digit (2..255)
//   TIMEOUT_CYC  cycles without an accept before stale asserts
//
// Ports
//   FPGA_CLK    in   system clock, rising edge
//   FPGA_RST    in   synchronous active-high reset
//   en_seg      in   [NUM_DIG]   digit enables, active-low, one-hot-low
//   data_seg    in   [4]         nibble for the enabled digit
//   dt          in   1           decimal point, active-low
//   digits      out  [4*NUM_DIG] captured nibbles, digit i at [4i+3:4i]
//   dp          out  [NUM_DIG]   captured decimal points, active-high
//   dig_valid   out  [NUM_DIG]   digit captured since reset / last stale
//   frame_done  out  1           one-cycle pulse on scan-frame wrap
//   scan_err    out  1           sticky: more than one enable seen low
//   stale       out  1           no accept within TIMEOUT_CYC
//
// Build option
//   SEG_CAPTURE_TIMEOUT_EN  when defined, the timeout counter and stale logic
//                           are built; otherwise stale is tied low and
//                           dig_valid / the frame mask clear only on reset.
// -----------------------------------------------------------------------------
module seg_scan_capture #(
  parameter int NUM_DIG     = 4,
  parameter int STABLE_CYC  = 4,
  parameter int TIMEOUT_CYC = 20_000_000
) (
  input  logic                   FPGA_CLK,
  input  logic                   FPGA_RST,
  input  logic [NUM_DIG-1:0]     en_seg,
  input  logic [3:0]             data_seg,
  input  logic                   dt,
  output logic [4*NUM_DIG-1:0]   digits,
  output logic [NUM_DIG-1:0]     dp,
  output logic [NUM_DIG-1:0]     dig_valid,
  output logic                   frame_done,
  output logic                   scan_err,
  output logic                   stale
);

  localparam int                 S_W      = NUM_DIG + 5;
  localparam int                 IDX_W    = (NUM_DIG > 2) ? 2 : 1;
  localparam logic [7:0]         STAB_MAX = 8'(STABLE_CYC);
  localparam logic [NUM_DIG-1:0] ZERO_D   = {NUM_DIG{1'b0}};
  localparam logic [NUM_DIG-1:0] ONE_D    = {{(NUM_DIG-1){1'b0}}, 1'b1};
  // Idle sample: every enable high, data zero, decimal point dark.
  localparam logic [S_W-1:0]     S_IDLE   = {{NUM_DIG{1'b1}}, 5'b0_0001};

  // Elaboration-time parameter sanity checks.
  if (NUM_DIG < 2 || NUM_DIG > 4) begin : g_bad_num_dig
    $error("seg_scan_capture: NUM_DIG must be 2..4");
  end
  if (STABLE_CYC < 2 || STABLE_CYC > 255) begin : g_bad_stable
    $error("seg_scan_capture: STABLE_CYC must be 2..255");
  end
  if (TIMEOUT_CYC < 1) begin : g_bad_timeout
    $error("seg_scan_capture: TIMEOUT_CYC must be positive");
  end

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DWELL = 2'd1,
    ST_HELD  = 2'd2
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [S_W-1:0]         r_s;
  logic [S_W-1:0]         r_s_prev;
  logic [7:0]             r_stab_cnt;
  logic [4*NUM_DIG-1:0]   r_digits;
  logic [NUM_DIG-1:0]     r_dp;
  logic [NUM_DIG-1:0]     r_valid;
  logic [NUM_DIG-1:0]     r_seen;
  logic                   r_frame;
  logic                   r_err;
  logic                   r_stale;

  logic [NUM_DIG-1:0]     w_en_low;
  logic [3:0]             w_data;
  logic                   w_dt;
  logic                   w_is_idle;
  logic                   w_is_multi;
  logic                   w_is_digit;
  logic                   w_same;
  logic [IDX_W-1:0]       w_idx;
  logic                   w_accept;
  logic                   w_load1;
  logic                   w_inc;
  logic                   w_coll;
  logic                   w_timeout;

  // Input stage: register the raw bus every cycle; keep the previous sample.
  always_ff @(posedge FPGA_CLK) begin
    if (FPGA_RST) begin
      r_s      <= S_IDLE;
      r_s_prev <= S_IDLE;
    end else begin
      r_s      <= {en_seg, data_seg, dt};
      r_s_prev <= r_s;
    end
  end

  // Classify the registered sample and encode the enabled digit index.
  always_comb begin
    w_en_low   = ~r_s[S_W-1:5];
    w_data     = r_s[4:1];
    w_dt       = r_s[0];
    w_is_idle  = (w_en_low == ZERO_D);
    // More than one bit low: clearing the lowest set bit leaves something.
    w_is_multi = ((w_en_low & (w_en_low - ONE_D)) != ZERO_D);
    w_is_digit = !w_is_idle && !w_is_multi;
    w_same     = (r_s == r_s_prev);
    w_idx      = {IDX_W{1'b0}};
    for (int k = 0; k < NUM_DIG; k++) begin
      if (w_en_low[k]) begin
        w_idx = IDX_W'(k);
      end else begin
        w_idx = w_idx;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge FPGA_CLK) begin
    if (FPGA_RST) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next state and per-cycle control strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_load1     = 1'b0;
    w_inc       = 1'b0;
    w_coll      = 1'b0;
    if (w_is_multi) begin
      // Collisions are discarded in every state.
      w_coll      = 1'b1;
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_is_digit) begin
            w_load1     = 1'b1;
            w_state_nxt = ST_DWELL;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
        ST_DWELL: begin
          if (w_same) begin
            // This sample brings the run to STABLE_CYC: accept now.
            if (r_stab_cnt >= (STAB_MAX - 8'd1)) begin
              w_accept    = 1'b1;
              w_state_nxt = ST_HELD;
            end else begin
              w_inc       = 1'b1;
              w_state_nxt = ST_DWELL;
            end
          end else if (w_is_digit) begin
            w_load1     = 1'b1;
            w_state_nxt = ST_DWELL;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
        ST_HELD: begin
          // One accept per dwell; any change restarts as from IDLE.
          if (w_same) begin
            w_state_nxt = ST_HELD;
          end else if (w_is_digit) begin
            w_load1     = 1'b1;
            w_state_nxt = ST_DWELL;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  // Stability counter: loaded with 1 on a new dwell, saturates at STABLE_CYC.
  always_ff @(posedge FPGA_CLK) begin
    if (FPGA_RST) begin
      r_stab_cnt <= 8'd0;
    end else if (w_load1) begin
      r_stab_cnt <= 8'd1;
    end else if (w_accept) begin
      r_stab_cnt <= STAB_MAX;
    end else if (w_inc) begin
      r_stab_cnt <= (r_stab_cnt < STAB_MAX) ? (r_stab_cnt + 8'd1) : r_stab_cnt;
    end else if (w_state_nxt == ST_IDLE) begin
      r_stab_cnt <= 8'd0;
    end else begin
      r_stab_cnt <= r_stab_cnt;
    end
  end

  // Captured digits, valid flags, frame mask/pulse and sticky collision flag.
  always_ff @(posedge FPGA_CLK) begin
    if (FPGA_RST) begin
      r_digits <= {(4*NUM_DIG){1'b0}};
      r_dp     <= ZERO_D;
      r_valid  <= ZERO_D;
      r_seen   <= ZERO_D;
      r_frame  <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_frame <= 1'b0;
      if (w_coll) begin
        r_err <= 1'b1;
      end
      if (w_accept) begin
        r_digits[4*int'(w_idx) +: 4] <= w_data;
        r_dp[w_idx]                  <= ~w_dt;
        r_valid[w_idx]               <= 1'b1;
        // A digit seen twice marks the start of a new frame.
        if (r_seen[w_idx]) begin
          r_frame <= 1'b1;
          r_seen  <= ONE_D << w_idx;
        end else begin
          r_seen[w_idx] <= 1'b1;
        end
      end else if (w_timeout) begin
        r_valid <= ZERO_D;
        r_seen  <= ZERO_D;
      end
    end
  end

`ifdef SEG_CAPTURE_TIMEOUT_EN
  localparam logic [31:0] TO_MAX = 32'(TIMEOUT_CYC);
  logic [31:0] r_to_cnt;

  // Timeout fires on the edge where the counter reaches TO_MAX; accept wins.
  assign w_timeout = !w_accept && (r_to_cnt != TO_MAX) &&
                     ((r_to_cnt + 32'd1) == TO_MAX);

  // Cycles-since-last-accept counter and stale flag; counter holds at TO_MAX.
  always_ff @(posedge FPGA_CLK) begin
    if (FPGA_RST) begin
      r_to_cnt <= 32'd0;
      r_stale  <= 1'b0;
    end else if (w_accept) begin
      r_to_cnt <= 32'd0;
      r_stale  <= 1'b0;
    end else if (r_to_cnt != TO_MAX) begin
      r_to_cnt <= r_to_cnt + 32'd1;
      if (w_timeout) begin
        r_stale <= 1'b1;
      end
    end else begin
      r_to_cnt <= r_to_cnt;
    end
  end
`else
  assign w_timeout = 1'b0;

  // Without the timeout feature stale never asserts.
  always_ff @(posedge FPGA_CLK) begin
    r_stale <= 1'b0;
  end
`endif

  assign digits     = r_digits;
  assign dp         = r_dp;
  assign dig_valid  = r_valid;
  assign frame_done = r_frame;
  assign scan_err   = r_err;
  assign stale      = r_stale;

endmodule

// File: tb/tb_seg_scan_capture.sv
module tb_seg_scan_capture;

  logic        FPGA_CLK = 1'b0;
  logic        FPGA_RST = 1'b0;
  logic [3:0]  en_seg   = 4'b1111;
  logic [3:0]  data_seg = 4'h0;
  logic        dt       = 1'b1;
  logic [15:0] digits;
  logic [3:0]  dp;
  logic [3:0]  dig_valid;
  logic        frame_done;
  logic        scan_err;
  logic        stale;

  int n_checks = 0;
  int n_fail   = 0;

  seg_scan_capture #(
    .NUM_DIG    (4),
    .STABLE_CYC (4),
    .TIMEOUT_CYC(100)
  ) dut (
    .FPGA_CLK  (FPGA_CLK),
    .FPGA_RST  (FPGA_RST),
    .en_seg    (en_seg),
    .data_seg  (data_seg),
    .dt        (dt),
    .digits    (digits),
    .dp        (dp),
    .dig_valid (dig_valid),
    .frame_done(frame_done),
    .scan_err  (scan_err),
    .stale     (stale)
  );

  always #5 FPGA_CLK = ~FPGA_CLK;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge FPGA_CLK);
      #1;
    end
  endtask

  task automatic drive(input logic [3:0] en, input logic [3:0] d, input logic p);
    en_seg   = en;
    data_seg = d;
    dt       = p;
  endtask

  task automatic do_reset();
    drive(4'b1111, 4'h0, 1'b1);
    FPGA_RST = 1'b1;
    tick(2);
    FPGA_RST = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if ({digits, dp, dig_valid, frame_done, scan_err, stale} !== 27'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h expected 0",
               {digits, dp, dig_valid, frame_done, scan_err, stale});
    end
  endtask

  task automatic test_single_accept();
    int pulses = 0;
    drive(4'b1110, 4'h5, 1'b1);
    tick(4);
    n_checks++;
    if (dig_valid !== 4'b0000) begin
      n_fail++;
      $display("FAIL accept_early: dig_valid got %b expected 0000", dig_valid);
    end
    tick(1);
    n_checks++;
    if (digits[3:0] !== 4'h5 || dp[0] !== 1'b0 || dig_valid !== 4'b0001) begin
      n_fail++;
      $display("FAIL accept_edge5: digits %h dp %b valid %b expected 5/0/0001",
               digits[3:0], dp[0], dig_valid);
    end
    for (int i = 0; i < 5; i++) begin
      tick(1);
      if (frame_done) pulses++;
    end
    n_checks++;
    if (pulses !== 0) begin
      n_fail++;
      $display("FAIL single_accept_once: frame pulses got %0d expected 0", pulses);
    end
  endtask

  task automatic test_glitch();
    drive(4'b1101, 4'h9, 1'b1);
    tick(2);
    drive(4'b1111, 4'h0, 1'b1);
    tick(6);
    n_checks++;
    if (digits !== 16'h0005 || dig_valid !== 4'b0001) begin
      n_fail++;
      $display("FAIL glitch_reject: digits %h valid %b expected 0005/0001",
               digits, dig_valid);
    end
  endtask

  task automatic test_alternate();
    int pulses = 0;
    do_reset();
    for (int r = 0; r < 3; r++) begin
      drive(4'b1110, 4'h3, 1'b0);
      for (int i = 0; i < 20; i++) begin
        tick(1);
        if (frame_done) pulses++;
      end
      drive(4'b1101, 4'h7, 1'b1);
      for (int i = 0; i < 20; i++) begin
        tick(1);
        if (frame_done) pulses++;
      end
    end
    n_checks++;
    if (digits !== 16'h0073) begin
      n_fail++;
      $display("FAIL alt_digits: got %h expected 0073", digits);
    end
    n_checks++;
    if (dp !== 4'b0001 || dig_valid !== 4'b0011) begin
      n_fail++;
      $display("FAIL alt_dp_valid: dp %b valid %b expected 0001/0011", dp, dig_valid);
    end
    n_checks++;
    if (pulses !== 2) begin
      n_fail++;
      $display("FAIL alt_frame_pulses: got %0d expected 2", pulses);
    end
  endtask

  task automatic test_collision();
    drive(4'b1100, 4'hF, 1'b0);
    tick(1);
    drive(4'b1011, 4'h4, 1'b1);
    n_checks++;
    if (scan_err !== 1'b0) begin
      n_fail++;
      $display("FAIL coll_early: scan_err got %b expected 0", scan_err);
    end
    tick(1);
    n_checks++;
    if (scan_err !== 1'b1 || digits !== 16'h0073) begin
      n_fail++;
      $display("FAIL coll_set: scan_err %b digits %h expected 1/0073", scan_err, digits);
    end
    tick(10);
    n_checks++;
    if (scan_err !== 1'b1 || digits !== 16'h0473 || dp !== 4'b0001) begin
      n_fail++;
      $display("FAIL coll_sticky: err %b digits %h dp %b expected 1/0473/0001",
               scan_err, digits, dp);
    end
    do_reset();
    n_checks++;
    if (scan_err !== 1'b0) begin
      n_fail++;
      $display("FAIL coll_reset_clear: scan_err got %b expected 0", scan_err);
    end
  endtask

  task automatic test_stale();
    logic       exp_stale;
    logic [3:0] exp_valid;
    logic       exp_frame;
`ifdef SEG_CAPTURE_TIMEOUT_EN
    exp_stale = 1'b1;
    exp_valid = 4'b0000;
    exp_frame = 1'b0;
`else
    exp_stale = 1'b0;
    exp_valid = 4'b0001;
    exp_frame = 1'b1;
`endif
    do_reset();
    drive(4'b1110, 4'h6, 1'b1);
    tick(5);
    n_checks++;
    if (dig_valid !== 4'b0001 || digits[3:0] !== 4'h6) begin
      n_fail++;
      $display("FAIL stale_first_accept: valid %b digit %h expected 0001/6",
               dig_valid, digits[3:0]);
    end
    drive(4'b1111, 4'h0, 1'b1);
    tick(99);
    n_checks++;
    if (stale !== 1'b0 || dig_valid !== 4'b0001) begin
      n_fail++;
      $display("FAIL stale_before: stale %b valid %b expected 0/0001", stale, dig_valid);
    end
    tick(1);
    n_checks++;
    if (stale !== exp_stale || dig_valid !== exp_valid) begin
      n_fail++;
      $display("FAIL stale_at_100: stale %b valid %b expected %b/%b",
               stale, dig_valid, exp_stale, exp_valid);
    end
    tick(10);
    drive(4'b1110, 4'h2, 1'b1);
    tick(5);
    n_checks++;
    if (stale !== 1'b0 || dig_valid !== 4'b0001 || digits[3:0] !== 4'h2) begin
      n_fail++;
      $display("FAIL stale_recover: stale %b valid %b digit %h expected 0/0001/2",
               stale, dig_valid, digits[3:0]);
    end
    n_checks++;
    if (frame_done !== exp_frame) begin
      n_fail++;
      $display("FAIL stale_seen_clear: frame_done got %b expected %b", frame_done, exp_frame);
    end
  endtask

  task automatic test_reset_mid_dwell();
    do_reset();
    drive(4'b0111, 4'h8, 1'b0);
    tick(4);
    FPGA_RST = 1'b1;
    tick(1);
    FPGA_RST = 1'b0;
    n_checks++;
    if ({digits, dp, dig_valid, frame_done, scan_err, stale} !== 27'd0) begin
      n_fail++;
      $display("FAIL mid_dwell_reset: got %h expected 0",
               {digits, dp, dig_valid, frame_done, scan_err, stale});
    end
    tick(4);
    n_checks++;
    if (dig_valid !== 4'b0000) begin
      n_fail++;
      $display("FAIL mid_dwell_early: valid got %b expected 0000", dig_valid);
    end
    tick(1);
    n_checks++;
    if (digits !== 16'h8000 || dp !== 4'b1000 || dig_valid !== 4'b1000) begin
      n_fail++;
      $display("FAIL mid_dwell_accept: digits %h dp %b valid %b expected 8000/1000/1000",
               digits, dp, dig_valid);
    end
  endtask

  initial begin
    test_reset();
    test_single_accept();
    test_glitch();
    test_alternate();
    test_collision();
    test_stale();
    test_reset_mid_dwell();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
